// File: rtl/axis_selector_sequencer_if.sv
// Bus bundle between the routing sequencer and its configuration/consumer side.
// Scalar clock and reset stay outside the bundle.
//
// Handshake semantics: there is no backpressure on this bus. cfg_commit is a
// single-cycle strobe that is always accepted. sel_gate acts as the "valid"
// for the routed data: consumers must treat data as valid only while
// sel_gate=1. slot_start marks the first cycle a new axis_selector word is
// presented. Every output of the sequencer is driven from a register.
interface axis_selector_sequencer_if #(
  parameter int NUM_SLOTS   = 4,
  parameter int DWELL_WIDTH = 32
);
  localparam int IW = $clog2(NUM_SLOTS);
  localparam int NW = IW + 1;

  // configuration side
  logic [NUM_SLOTS*32-1:0] cfg_slots;
  logic [NW-1:0]           cfg_num_slots;
  logic [DWELL_WIDTH-1:0]  cfg_dwell;
  logic                    cfg_commit;
  logic                    enable;

  // routing / status side
  logic [31:0]             axis_selector;
  logic                    sel_gate;
  logic [IW-1:0]           slot_index;
  logic                    slot_start;
  logic                    running;
  logic                    cfg_pending;
  logic [1:0]              dbg_state;

  // controller / testbench view
  modport master (
    output cfg_slots, cfg_num_slots, cfg_dwell, cfg_commit, enable,
    input  axis_selector, sel_gate, slot_index, slot_start, running,
           cfg_pending, dbg_state
  );

  // sequencer view
  modport slave (
    input  cfg_slots, cfg_num_slots, cfg_dwell, cfg_commit, enable,
    output axis_selector, sel_gate, slot_index, slot_start, running,
           cfg_pending, dbg_state
  );
endinterface

// File: rtl/axis_selector_sequencer.sv
// axis_selector_sequencer: steps round-robin through committed routing words
// for the 6-output AXIS selector, holding each for a programmable dwell and
// gating the data low while the selector's input register refills after a
// route change. Configuration is double-buffered (shadow -> active) and the
// active set only changes on an IDLE exit or a slot boundary.
module axis_selector_sequencer #(
  parameter int NUM_SLOTS     = 4,
  parameter int DWELL_WIDTH   = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                      a_clk,
  input logic                      reset,
  axis_selector_sequencer_if.slave bus
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam int NW = IW + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;

  // shadow set, written by cfg_commit (raw values)
  logic [31:0]            r_sh_slots [NUM_SLOTS];
  logic [NW-1:0]          r_sh_num;
  logic [DWELL_WIDTH-1:0] r_sh_dwell;

  // active set, sanitised copy of shadow
  logic [31:0]            r_act_slots [NUM_SLOTS];
  logic [NW-1:0]          r_act_num;
  logic [DWELL_WIDTH-1:0] r_act_dwell;
  logic                   r_pending;

  // sequencer state and registered outputs
  state_t                 r_state;
  logic [DWELL_WIDTH-1:0] r_dwell_cnt;
  logic [SW-1:0]          r_settle_cnt;
  logic [IW-1:0]          r_idx;
  logic [31:0]            r_axis_sel;
  logic                   r_gate;
  logic                   r_slot_start;
  logic                   r_running;

  logic                   w_dwell_last;
  logic                   w_boundary;
  logic                   w_apply;
  logic                   w_idx_last;
  logic [IW-1:0]          w_next_idx;
  logic [31:0]            w_next_word;
  logic [NW-1:0]          w_san_num;
  logic [DWELL_WIDTH-1:0] w_san_dwell;

  // Boundary detection, next slot selection and shadow sanitising.
  // The dwell counter only counts up to dwell-1, so the maximum dwell value
  // never needs a wider counter.
  always_comb begin
    w_dwell_last = (r_state == ST_DWELL) &&
                   (r_dwell_cnt == r_act_dwell - DWELL_WIDTH'(1));
    w_boundary   = bus.enable && ((r_state == ST_IDLE) || w_dwell_last);
    w_apply      = w_boundary && r_pending;
    w_idx_last   = ({1'b0, r_idx} == r_act_num - NW'(1));

    w_next_idx = '0;
    if ((r_state == ST_DWELL) && !r_pending && !w_idx_last) begin
      w_next_idx = r_idx + IW'(1);
    end
    // a pending set restarts at its own slot 0
    w_next_word = r_pending ? r_sh_slots[0] : r_act_slots[w_next_idx];

    w_san_num = r_sh_num;
    if (r_sh_num == '0) begin
      w_san_num = NW'(1);
    end else if (r_sh_num > NW'(NUM_SLOTS)) begin
      w_san_num = NW'(NUM_SLOTS);
    end
    w_san_dwell = (r_sh_dwell == '0) ? DWELL_WIDTH'(1) : r_sh_dwell;
  end

  // Shadow capture on commit, shadow->active copy on a boundary event.
  // A commit in the same cycle as a boundary lands in shadow only and keeps
  // pending set, so it is applied at the following boundary.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        r_sh_slots[k]  <= '0;
        r_act_slots[k] <= '0;
      end
      r_sh_num    <= NW'(1);
      r_sh_dwell  <= DWELL_WIDTH'(1);
      r_act_num   <= NW'(1);
      r_act_dwell <= DWELL_WIDTH'(1);
      r_pending   <= 1'b0;
    end else begin
      if (bus.cfg_commit) begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          r_sh_slots[k] <= bus.cfg_slots[32*k +: 32];
        end
        r_sh_num   <= bus.cfg_num_slots;
        r_sh_dwell <= bus.cfg_dwell;
      end
      if (w_apply) begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          r_act_slots[k] <= r_sh_slots[k];
        end
        r_act_num   <= w_san_num;
        r_act_dwell <= w_san_dwell;
      end
      if (bus.cfg_commit) begin
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Sequencer FSM: IDLE -> SETTLE (gate low) -> DWELL (gate high), looping
  // through slots; an unchanged word skips SETTLE. enable low forces IDLE.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dwell_cnt  <= '0;
      r_settle_cnt <= '0;
      r_idx        <= '0;
      r_axis_sel   <= '0;
      r_gate       <= 1'b0;
      r_slot_start <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_slot_start <= 1'b0;
      if (!bus.enable) begin
        r_state      <= ST_IDLE;
        r_gate       <= 1'b0;
        r_running    <= 1'b0;
        r_idx        <= '0;
        r_dwell_cnt  <= '0;
        r_settle_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_axis_sel   <= w_next_word;
            r_idx        <= w_next_idx;
            r_slot_start <= 1'b1;
            r_running    <= 1'b1;
            r_gate       <= 1'b0;
            r_settle_cnt <= '0;
            r_state      <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (r_settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
              r_state     <= ST_DWELL;
              r_gate      <= 1'b1;
              r_dwell_cnt <= '0;
            end else begin
              r_settle_cnt <= r_settle_cnt + SW'(1);
            end
          end
          ST_DWELL: begin
            if (w_dwell_last) begin
              r_idx        <= w_next_idx;
              r_axis_sel   <= w_next_word;
              r_slot_start <= 1'b1;
              r_dwell_cnt  <= '0;
              if (w_next_word == r_axis_sel) begin
                // same route: the selector register needs no refill
                r_gate <= 1'b1;
              end else begin
                r_gate       <= 1'b0;
                r_settle_cnt <= '0;
                r_state      <= ST_SETTLE;
              end
            end else begin
              r_dwell_cnt <= r_dwell_cnt + DWELL_WIDTH'(1);
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_gate    <= 1'b0;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.axis_selector = r_axis_sel;
  assign bus.sel_gate      = r_gate;
  assign bus.slot_index    = r_idx;
  assign bus.slot_start    = r_slot_start;
  assign bus.running       = r_running;
  assign bus.cfg_pending   = r_pending;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_axis_selector_sequencer.sv
// Testbench for axis_selector_sequencer. Stimulus pushes the expected slot
// sequence (word, index, and the period/gate-high count of the preceding
// slot) into exp_q; a monitor pops one entry on every slot_start.
module tb_axis_selector_sequencer;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int SC = 2;
  localparam int W  = 72;  // {word[31:0], idx[7:0], prev_period[15:0], prev_gate[15:0]}

  logic a_clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [W-1:0] exp_q[$];

  axis_selector_sequencer_if #(.NUM_SLOTS(NS), .DWELL_WIDTH(DW)) bus();

  axis_selector_sequencer #(
    .NUM_SLOTS(NS), .DWELL_WIDTH(DW), .SETTLE_CYCLES(SC)
  ) dut (
    .a_clk (a_clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 a_clk = ~a_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] s0, input logic [31:0] s1,
                                         input logic [31:0] s2, input logic [31:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic push_exp(input logic [31:0] w, input int idx, input int p, input int g);
    exp_q.push_back({w, 8'(idx), 16'(p), 16'(g)});
  endtask

  // called at a negedge; leaves the bench at the following negedge
  task automatic do_commit(input logic [127:0] slots, input logic [2:0] num, input logic [7:0] dwell);
    bus.cfg_slots     = slots;
    bus.cfg_num_slots = num;
    bus.cfg_dwell     = dwell;
    bus.cfg_commit    = 1'b1;
    @(negedge a_clk);
    bus.cfg_commit = 1'b0;
    check("pending_after_commit", 64'(bus.cfg_pending), 64'd1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge a_clk);
      #1;
      k++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic stop_seq(input string tag);
    bus.enable = 1'b0;
    @(negedge a_clk);
    check({tag, "_gate_off"},  64'(bus.sel_gate),   64'd0);
    check({tag, "_not_run"},   64'(bus.running),    64'd0);
    check({tag, "_idx_zero"},  64'(bus.slot_index), 64'd0);
    check({tag, "_idle"},      64'(bus.dbg_state),  64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_axis"},    64'(bus.axis_selector), 64'd0);
    check({tag, "_gate"},    64'(bus.sel_gate),      64'd0);
    check({tag, "_idx"},     64'(bus.slot_index),    64'd0);
    check({tag, "_start"},   64'(bus.slot_start),    64'd0);
    check({tag, "_running"}, 64'(bus.running),       64'd0);
    check({tag, "_pending"}, 64'(bus.cfg_pending),   64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    int cnt;
    int gcnt;
    logic [W-1:0] e;
    cnt  = 0;
    gcnt = 0;
    forever begin
      @(negedge a_clk);
      if (reset) begin
        cnt  = 0;
        gcnt = 0;
      end else if (bus.slot_start) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_slot_start: word 0x%0h idx %0d, none expected",
                   bus.axis_selector, bus.slot_index);
        end else begin
          e = exp_q.pop_front();
          check("slot_word",  64'(bus.axis_selector), 64'(e[71:40]));
          check("slot_index", 64'(bus.slot_index),    64'(e[39:32]));
          if (e[31:16] != 16'd0) begin
            check("slot_period", 64'(cnt),  64'(e[31:16]));
            check("gate_high",   64'(gcnt), 64'(e[15:0]));
          end
        end
        cnt  = 1;
        gcnt = bus.sel_gate ? 1 : 0;
      end else begin
        cnt++;
        if (bus.sel_gate) gcnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int   k;
    logic ok;
    bus.cfg_slots     = '0;
    bus.cfg_num_slots = 3'd1;
    bus.cfg_dwell     = 8'd1;
    bus.cfg_commit    = 1'b0;
    bus.enable        = 1'b0;
    reset             = 1'b1;
    repeat (3) @(negedge a_clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge a_clk);

    // basic rotation: 0,1,2,3,0 with 7-cycle period, gate high 5
    do_commit(pack4(32'h000000, 32'h111111, 32'h222222, 32'h333333), 3'd4, 8'd5);
    push_exp(32'h000000, 0, 0, 0);
    push_exp(32'h111111, 1, 7, 5);
    push_exp(32'h222222, 2, 7, 5);
    push_exp(32'h333333, 3, 7, 5);
    push_exp(32'h000000, 0, 7, 5);
    bus.enable = 1'b1;
    @(negedge a_clk);
    check("t1_running_after_enable", 64'(bus.running),     64'd1);
    check("t1_pending_applied",      64'(bus.cfg_pending), 64'd0);
    check("t1_gate_low_settle",      64'(bus.sel_gate),    64'd0);
    @(negedge a_clk);
    check("t1_gate_low_settle2",     64'(bus.sel_gate),    64'd0);
    @(negedge a_clk);
    check("t1_gate_rises",           64'(bus.sel_gate),    64'd1);
    drain(200);
    stop_seq("t1");

    // unchanged word: one slot, dwell 3
    do_commit(pack4(32'hABCDEF, 32'h0, 32'h0, 32'h0), 3'd1, 8'd3);
    push_exp(32'hABCDEF, 0, 0, 0);
    push_exp(32'hABCDEF, 0, 5, 3);
    push_exp(32'hABCDEF, 0, 3, 3);
    push_exp(32'hABCDEF, 0, 3, 3);
    bus.enable = 1'b1;
    drain(200);
    stop_seq("t2");

    // commit mid-dwell of slot 2
    do_commit(pack4(32'h10, 32'h20, 32'h30, 32'h40), 3'd4, 8'd4);
    push_exp(32'h10,  0, 0, 0);
    push_exp(32'h20,  1, 6, 4);
    push_exp(32'h30,  2, 6, 4);
    push_exp(32'hB00, 0, 6, 4);
    push_exp(32'hB11, 1, 5, 3);
    push_exp(32'hB00, 0, 5, 3);
    bus.enable = 1'b1;
    k = 0;
    while (!(bus.slot_index == 2'd2 && bus.sel_gate) && k < 200) begin
      @(negedge a_clk);
      k++;
    end
    check("t3_reach_slot2_dwell", 64'(bus.slot_index == 2'd2 && bus.sel_gate), 64'd1);
    do_commit(pack4(32'hB00, 32'hB11, 32'h0, 32'h0), 3'd2, 8'd3);
    ok = 1'b1;
    k = 0;
    while (!bus.slot_start && k < 20) begin
      if (bus.cfg_pending !== 1'b1 || bus.axis_selector !== 32'h30) ok = 1'b0;
      @(negedge a_clk);
      k++;
    end
    check("t3_old_word_and_pending_hold", 64'(ok), 64'd1);
    check("t3_pending_cleared_at_boundary", 64'(bus.cfg_pending), 64'd0);
    drain(200);
    stop_seq("t3");

    // commit on the exact boundary cycle ending slot 2
    do_commit(pack4(32'h10, 32'h20, 32'h30, 32'h40), 3'd4, 8'd4);
    push_exp(32'h10, 0, 0, 0);
    push_exp(32'h20, 1, 6, 4);
    push_exp(32'h30, 2, 6, 4);
    push_exp(32'h40, 3, 6, 4);
    push_exp(32'hC0, 0, 6, 4);
    push_exp(32'hC1, 1, 5, 3);
    push_exp(32'hC0, 0, 5, 3);
    bus.enable = 1'b1;
    k = 0;
    while (!(bus.slot_start && bus.slot_index == 2'd2) && k < 200) begin
      @(negedge a_clk);
      k++;
    end
    check("t4_reach_slot2_start", 64'(bus.slot_start && bus.slot_index == 2'd2), 64'd1);
    repeat (5) @(negedge a_clk);
    do_commit(pack4(32'hC0, 32'hC1, 32'h0, 32'h0), 3'd2, 8'd3);
    check("t4_boundary_start",   64'(bus.slot_start),    64'd1);
    check("t4_boundary_old_idx", 64'(bus.slot_index),    64'd3);
    check("t4_boundary_old_word",64'(bus.axis_selector), 64'h40);
    drain(200);
    stop_seq("t4");

    // degenerate config: dwell 0 and num_slots 0 act as dwell 1, one slot
    do_commit(pack4(32'h00D00D, 32'h111, 32'h0, 32'h0), 3'd0, 8'd0);
    push_exp(32'h00D00D, 0, 0, 0);
    push_exp(32'h00D00D, 0, 3, 1);
    push_exp(32'h00D00D, 0, 1, 1);
    push_exp(32'h00D00D, 0, 1, 1);
    bus.enable = 1'b1;
    drain(100);
    stop_seq("t5");

    // oversize num_slots, then stop during SETTLE and restart at slot 0
    do_commit(pack4(32'h1, 32'h2, 32'h3, 32'h4), 3'd7, 8'd2);
    push_exp(32'h1, 0, 0, 0);
    bus.enable = 1'b1;
    drain(100);
    check("t5_in_settle", 64'(bus.dbg_state), 64'd1);
    stop_seq("t5_settle_stop");
    push_exp(32'h1, 0, 0, 0);
    push_exp(32'h2, 1, 4, 2);
    push_exp(32'h3, 2, 4, 2);
    push_exp(32'h4, 3, 4, 2);
    push_exp(32'h1, 0, 4, 2);
    bus.enable = 1'b1;
    drain(200);
    stop_seq("t5_restart");

    // maximum dwell for an 8-bit counter
    do_commit(pack4(32'h5, 32'h6, 32'h0, 32'h0), 3'd2, 8'd255);
    push_exp(32'h5, 0, 0, 0);
    push_exp(32'h6, 1, 257, 255);
    push_exp(32'h5, 0, 257, 255);
    bus.enable = 1'b1;
    drain(1000);

    // reset mid-dwell with a pending commit
    k = 0;
    while (!bus.sel_gate && k < 20) begin
      @(negedge a_clk);
      k++;
    end
    check("t7_in_dwell", 64'(bus.dbg_state), 64'd2);
    do_commit(pack4(32'h77, 32'h88, 32'h0, 32'h0), 3'd2, 8'd9);
    reset      = 1'b1;
    bus.enable = 1'b0;
    @(negedge a_clk);
    check_reset_values("t7_reset");
    reset = 1'b0;
    push_exp(32'h0, 0, 0, 0);
    push_exp(32'h0, 0, 3, 1);
    bus.enable = 1'b1;
    drain(100);
    stop_seq("t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
